seq_alu: RTL and testbench

//   Parametrised multi-cycle ALU for the next-generation CPU datapath; supports the same 3-bit SELECT op set.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/seq_alu_iter.sv | 71 +++++++
 rtl/seq_alu.sv | 130 +++++++++++++
 tb/tb_seq_alu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : SELECT opcodes and FSM state encoding for seq_alu
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_SL   = 3'b101;
    localparam logic [2:0] OP_SRA  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Every opcode with bit 2 set runs on the iterative engine.
    function automatic logic is_iter_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_iter.sv
// ============================================================================
// Module      : seq_alu_iter
// Description : 1-bit/cycle shift-add multiplier and shifter with down-counter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SHW:0]     i_n,
    output logic             o_done,
    output logic [WIDTH-1:0] o_value
);

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] w_next_acc;

    always_comb begin
        w_next_acc = r_acc;
        case (r_op)
            OP_MULT: w_next_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
            OP_SL:   w_next_acc = {r_acc[WIDTH-2:0], 1'b0};
            OP_SRA:  w_next_acc = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            OP_ROR:  w_next_acc = {r_acc[0], r_acc[WIDTH-1:1]};
            default: w_next_acc = r_acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_FWD;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_op     <= i_op;
            r_acc    <= (i_op == OP_MULT) ? '0 : i_a;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_cnt    <= i_n;
        end else if (r_cnt != '0) begin
            r_acc    <= w_next_acc;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // The step taken on the edge where r_cnt==1 is the final one, so the
    // owner captures o_value on that same edge.
    assign o_done  = (r_cnt == {{SHW{1'b0}}, 1'b1});
    assign o_value = w_next_acc;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with START/BUSY/DONE handshake
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [2:0]       i_select,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] C_WIDTH_N = (SHW+1)'(WIDTH);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_simple;
    logic             w_big_shift;
    logic [SHW:0]     w_n;
    logic             w_load;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_value;

    assign w_sum       = i_data1 + i_data2;
    assign w_add_ovf   = (i_data1[WIDTH-1] == i_data2[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != i_data1[WIDTH-1]);
    // Any bit at or above SHW set means the amount is >= WIDTH.
    assign w_big_shift = |i_data2[WIDTH-1:SHW];

    always_comb begin
        w_n = '0;
        case (i_select)
            OP_MULT:       w_n = C_WIDTH_N;
            OP_SL, OP_SRA: w_n = w_big_shift ? C_WIDTH_N : {1'b0, i_data2[SHW-1:0]};
            OP_ROR:        w_n = {1'b0, i_data2[SHW-1:0]};
            default:       w_n = '0;
        endcase
    end

    // Zero-length shifts and rotates fall through to the FWD path.
    always_comb begin
        w_simple = i_data1;
        case (i_select)
            OP_ADD:  w_simple = w_sum;
            OP_AND:  w_simple = i_data1 & i_data2;
            OP_OR:   w_simple = i_data1 | i_data2;
            default: w_simple = i_data1;
        endcase
    end

    assign w_load = (r_state == ST_IDLE) && i_start && is_iter_op(i_select) && (w_n != '0);

    seq_alu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_op    (i_select),
        .i_a     (i_data1),
        .i_b     (i_data2),
        .i_n     (w_n),
        .o_done  (w_iter_done),
        .o_value (w_iter_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_start) begin
                    if (w_load) begin
                        r_state <= ST_EXEC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_result <= w_simple;
                        r_zero   <= (w_simple == '0);
                        r_ovf    <= (i_select == OP_ADD) && w_add_ovf;
                        r_done   <= 1'b1;
                    end
                end
            end else if (w_iter_done) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_result <= w_iter_value;
                r_zero   <= (w_iter_value == '0);
                r_ovf    <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_zero   = r_zero;
    assign o_ovf    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Scoreboard testbench for seq_alu (WIDTH=8)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data1 = '0;
    logic [W-1:0] data2 = '0;
    logic [2:0]   sel = 3'b000;
    logic         busy, done, zero, ovf;
    logic [W-1:0] result;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (start),
        .i_data1  (data1),
        .i_data2  (data2),
        .i_select (sel),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_zero   (zero),
        .o_ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        int           edge_no;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecount  = 0;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iter_n(input logic [2:0] op, input logic [W-1:0] b);
        case (op)
            3'b100:         return W;
            3'b101, 3'b110: return (int'(b) >= W) ? W : int'(b);
            3'b111:         return int'(b) % W;
            default:        return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t                e;
        int                  s;
        int                  n;
        logic signed [W-1:0] sa;
        logic [2*W-1:0]      d;
        n     = iter_n(op, b);
        e.ovf = 1'b0;
        e.res = a;
        case (op)
            3'b001: begin
                s     = int'($signed(a)) + int'($signed(b));
                e.res = W'(s);
                e.ovf = (s > 127) || (s < -128);
            end
            3'b010: e.res = a & b;
            3'b011: e.res = a | b;
            3'b100: begin
                s     = int'($signed(a)) * int'($signed(b));
                e.res = W'(s);
            end
            3'b101: e.res = (n >= W) ? '0 : (a << n);
            3'b110: begin
                sa    = a;
                e.res = sa >>> n;
            end
            3'b111: begin
                d     = {a, a} >> n;
                e.res = d[W-1:0];
            end
            default: e.res = a;
        endcase
        e.zero    = (e.res == '0);
        e.edge_no = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("zero", 32'(zero), 32'(e.zero));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("done_edge", ecount, e.edge_no);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        n = iter_n(op, b);
        e = model(op, a, b);
        @(negedge clk);
        data1     = a;
        data2     = b;
        sel       = op;
        start     = 1'b1;
        e.edge_no = ecount + 1 + n;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), (n > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (sbq.size() != 0 || busy) begin
            @(negedge clk);
            cyc++;
            if (cyc > 40) begin
                check("idle_timeout", 32'd1, 32'd0);
                sbq.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b);
        wait_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        run(3'b001, 8'd100, 8'd27);
        run(3'b001, 8'd100, 8'd28);
        run(3'b100, 8'hFD, 8'd5);
        run(3'b100, 8'd0, 8'd77);
        run(3'b110, 8'h90, 8'd3);
        run(3'b101, 8'h01, 8'd10);
        run(3'b111, 8'h81, 8'd9);
        run(3'b111, 8'h81, 8'd8);
        run(3'b000, 8'h5A, 8'h00);
        run(3'b010, 8'hF0, 8'h3C);
        run(3'b011, 8'h00, 8'h00);
        run(3'b110, 8'h80, 8'd200);
        run(3'b101, 8'hA5, 8'd0);

        // Requests issued while a MULT is running must be dropped.
        issue(3'b100, 8'd7, 8'd9);
        for (int i = 0; i < 8; i++) begin
            start = 1'b1;
            data1 = W'($urandom);
            data2 = W'($urandom_range(1, 5));
            sel   = (i % 2 == 0) ? 3'b001 : 3'b100;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("no_stray_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run(op, W'($urandom), op[2] ? W'($urandom_range(0, 12)) : W'($urandom));
        end

        // Asynchronous reset in the middle of a MULT.
        run(3'b001, 8'd120, 8'd10);
        issue(3'b100, 8'd3, 8'd5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_zero", 32'(zero), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        run(3'b001, 8'd1, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
